// File: rtl/rotation_phase_gen.sv
// rotation_phase_gen
//   Measures the revolution period from debounced break-beam rising edges and
//   subdivides each revolution into 2^THETA_BITS equal angle steps for the
//   texture-column mapper.
//
//   Ports
//     clk          system clock, all logic on the rising edge
//     reset        synchronous active-low reset
//     break_clean  debounced break-beam level; rising edge = revolution start
//     theta        current angle step (0 outside the locked state)
//     period       last accepted edge-to-edge distance in cycles
//     locked       high while theta tracks a measured period
//     rev_strobe   one-cycle pulse per accepted edge
//
//   MIN_PERIOD must be >= 2^THETA_BITS so step_len can never be zero.
module rotation_phase_gen #(
  parameter int THETA_BITS  = 6,
  parameter int PERIOD_BITS = 28,
  parameter int MIN_PERIOD  = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   break_clean,
  output logic [THETA_BITS-1:0]  theta,
  output logic [PERIOD_BITS-1:0] period,
  output logic                   locked,
  output logic                   rev_strobe
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCK    = 2'd2
  } state_t;

  localparam logic [PERIOD_BITS-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_BITS-1:0] MIN_P     = PERIOD_BITS'(MIN_PERIOD);
  localparam logic [THETA_BITS-1:0]  THETA_MAX = '1;

  state_t                 state_q, state_d;
  logic                   prev;
  logic [PERIOD_BITS-1:0] cnt;
  logic [PERIOD_BITS-1:0] step_len;
  logic [PERIOD_BITS-1:0] step_cnt;

  logic edge_det, accept, timeout;

  assign edge_det = break_clean & ~prev;
  // The first edge after IDLE has no reference, so it is taken regardless of cnt.
  assign accept   = edge_det && ((state_q == IDLE) || (cnt >= MIN_P));
  // Saturated counter means the rotor stopped (or never started again).
  assign timeout  = (cnt == CNT_MAX) && (state_q != IDLE);

  assign locked   = (state_q == LOCK);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; an accepted edge outranks a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACQUIRE;
      ACQUIRE: if (accept) state_d = LOCK;
               else if (timeout) state_d = IDLE;
      LOCK:    if (!accept && timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: period counter, period/step latch, theta stepping
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev       <= 1'b0;
      cnt        <= '0;
      period     <= '0;
      step_len   <= '0;
      step_cnt   <= '0;
      theta      <= '0;
      rev_strobe <= 1'b0;
    end else begin
      prev       <= break_clean;
      rev_strobe <= accept;

      // cnt is 1 the cycle after an edge, so at the next edge it equals the
      // exact edge-to-edge distance.
      if (accept)               cnt <= {{(PERIOD_BITS-1){1'b0}}, 1'b1};
      else if (cnt != CNT_MAX)  cnt <= cnt + 1'b1;

      if (accept) begin
        theta    <= '0;
        step_cnt <= '0;
        if (state_q != IDLE) begin
          period   <= cnt;
          step_len <= cnt >> THETA_BITS;
        end
      end else if (timeout) begin
        theta    <= '0;
        step_cnt <= '0;
      end else if (state_q == LOCK) begin
        if (step_cnt == step_len - 1'b1) begin
          step_cnt <= '0;
          // Hold the last column if the rotor slows down.
          if (theta != THETA_MAX) theta <= theta + 1'b1;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rotation_phase_gen.sv
module tb_rotation_phase_gen;

  localparam int TB = 6;
  localparam int PB = 14;
  localparam int MP = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          break_clean = 1'b0;
  logic [TB-1:0] theta;
  logic [PB-1:0] period;
  logic          locked;
  logic          rev_strobe;

  rotation_phase_gen #(.THETA_BITS(TB), .PERIOD_BITS(PB), .MIN_PERIOD(MP)) dut (
    .clk(clk), .reset(reset), .break_clean(break_clean),
    .theta(theta), .period(period), .locked(locked), .rev_strobe(rev_strobe)
  );

  always #5 clk = ~clk;

  // Checkpoint: revolution id, cycle offset from that revolution's edge cycle
  // (rel 0 = the cycle break_clean rises), expected outputs; -1 = don't check.
  typedef struct {
    int rev;
    int rel;
    int th;
    int lk;
    int per;
    int st;
  } vec_t;

  vec_t tbl[$];
  int   npass = 0;
  int   ntot  = 0;

  task automatic chk(input string name, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input int rv, input int rl, input int th, input int lk,
                     input int per, input int st);
    vec_t v;
    v.rev = rv; v.rel = rl; v.th = th; v.lk = lk; v.per = per; v.st = st;
    tbl.push_back(v);
  endtask

  // One revolution: sample at each negedge, then drive the line for the
  // cycle. Optional glitch re-raises the line 50 cycles after the edge.
  task automatic rev(input int id, input int len, input bit glitch);
    for (int r = 0; r < len; r++) begin
      @(negedge clk);
      foreach (tbl[i]) begin
        if (tbl[i].rev == id && tbl[i].rel == r) begin
          string tag;
          tag = $sformatf("rev%0d_rel%0d", id, r);
          if (tbl[i].th  >= 0) chk({tag, "_theta"},  int'(theta),      tbl[i].th);
          if (tbl[i].lk  >= 0) chk({tag, "_locked"}, int'(locked),     tbl[i].lk);
          if (tbl[i].per >= 0) chk({tag, "_period"}, int'(period),     tbl[i].per);
          if (tbl[i].st  >= 0) chk({tag, "_strobe"}, int'(rev_strobe), tbl[i].st);
        end
      end
      if (r == 0)                    break_clean = 1'b1;
      else if (r == 10)              break_clean = 1'b0;
      else if (glitch && r == 50)    break_clean = 1'b1;
      else if (glitch && r == 60)    break_clean = 1'b0;
    end
  endtask

  initial begin
    // rev0: first edge from IDLE -> ACQUIRE, nothing latched yet
    add(0, 1,    0, 0, 0, 1);
    add(0, 2,    0, 0, 0, 0);
    add(0, 6399, 0, 0, 0, 0);
    // rev1: locks with period 6400 (step 100); glitch at rel 50 ignored
    add(1, 1,    0, 1, 6400, 1);
    add(1, 51,   0, 1, 6400, 0);
    add(1, 61,   0, 1, 6400, 0);
    add(1, 100,  0, -1, -1, 0);
    add(1, 101,  1, -1, -1, -1);
    add(1, 201,  2, -1, -1, -1);
    add(1, 6300, 62, -1, -1, -1);
    add(1, 6301, 63, -1, -1, -1);
    add(1, 6399, 63, 1, 6400, 0);
    // rev2: step 100, early edge at 3200 cuts theta at 31
    add(2, 1,    0, 1, 6400, 1);
    add(2, 3199, 31, 1, -1, -1);
    // rev3: period 3200 -> step 50; long revolution holds theta at 63
    add(3, 1,     0, 1, 3200, 1);
    add(3, 50,    0, -1, -1, -1);
    add(3, 51,    1, -1, -1, -1);
    add(3, 3150,  62, -1, -1, -1);
    add(3, 3151,  63, -1, -1, -1);
    add(3, 12799, 63, 1, 3200, 0);
    // rev4: period 12800 -> step 200
    add(4, 1,   0, 1, 12800, 1);
    add(4, 200, 0, -1, -1, -1);
    add(4, 201, 1, -1, -1, -1);
    add(4, 401, 2, -1, -1, -1);
    // rev5: edges stop; cnt saturates at 16383 -> IDLE, period kept
    add(5, 1,     0, 1, 6400, 1);
    add(5, 16383, 63, 1, 6400, 0);
    add(5, 16384, 0, 0, 6400, 0);
    add(5, 16389, 0, 0, 6400, 0);
    // rev6: edge from IDLE after timeout: strobe but not locked
    add(6, 1, 0, 0, 6400, 1);
    // rev7: relocks, theta 20 before the reset
    add(7, 1,    0, 1, 6400, 1);
    add(7, 2049, 20, 1, 6400, 0);
    // rev8/9: after reset two fresh edges needed
    add(8, 1,    0, 0, 0, 1);
    add(8, 6399, 0, 0, 0, 0);
    add(9, 1,    0, 1, 6400, 1);

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_theta",  int'(theta),      0);
    chk("reset_period", int'(period),     0);
    chk("reset_locked", int'(locked),     0);
    chk("reset_strobe", int'(rev_strobe), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_locked", int'(locked), 0);

    rev(0, 6400, 1'b0);
    rev(1, 6400, 1'b1);
    rev(2, 3200, 1'b0);
    rev(3, 12800, 1'b0);
    rev(4, 6400, 1'b0);
    rev(5, 16390, 1'b0);
    rev(6, 6400, 1'b0);
    rev(7, 2050, 1'b0);

    // mid-revolution reset
    @(negedge clk);
    chk("pre_rst_theta", int'(theta), 20);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_theta",  int'(theta),      0);
    chk("rst_period", int'(period),     0);
    chk("rst_locked", int'(locked),     0);
    chk("rst_strobe", int'(rev_strobe), 0);
    reset = 1'b1;

    rev(8, 6400, 1'b0);
    rev(9, 10, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
